// File: rtl/button_cmd_queue_if.sv
// Handshake bundle between the button debouncers / game controller and button_cmd_queue.
// master = debouncer + controller side, slave = the queue itself.
interface button_cmd_queue_if #(
  parameter int DEPTH = 4
);
  localparam int COL_W = 3;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             btn_left;
  logic             btn_right;
  logic             btn_drop;
  logic [COL_W-1:0] cursor_col;
  logic             cmd_valid;
  logic [COL_W-1:0] cmd_col;
  logic             cmd_ready;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  modport master (
    output btn_left, btn_right, btn_drop, cmd_ready,
    input  cursor_col, cmd_valid, cmd_col, fifo_count, overflow
  );

  modport slave (
    input  btn_left, btn_right, btn_drop, cmd_ready,
    output cursor_col, cmd_valid, cmd_col, fifo_count, overflow
  );
endinterface

// File: rtl/button_cmd_queue.sv
// Cursor tracker plus drop-command FIFO feeding the Connect4 controller over valid/ready.
// Optional macro CURSOR_WRAP_EN: cursor wraps at the board edges instead of saturating.
module button_cmd_queue #(
  parameter int NUM_COLS  = 7,
  parameter int DEPTH     = 4,
  parameter int START_COL = 3
) (
  input logic                clk,
  input logic                rst_n,
  button_cmd_queue_if.slave  bus
);
  localparam int COL_W = 3;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = CNT_W - 1;
  localparam logic [COL_W-1:0] MAX_COL = COL_W'(NUM_COLS - 1);

  logic [COL_W-1:0] r_cursor, w_cursor_nxt;
  logic [COL_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             w_valid, w_full, w_pop, w_wr_en;

  always_comb begin
    w_cursor_nxt = r_cursor;
    if (bus.btn_left && !bus.btn_right) begin
      if (r_cursor == '0) begin
`ifdef CURSOR_WRAP_EN
        w_cursor_nxt = MAX_COL;
`else
        w_cursor_nxt = r_cursor;
`endif
      end else begin
        w_cursor_nxt = r_cursor - 1'b1;
      end
    end else if (bus.btn_right && !bus.btn_left) begin
      if (r_cursor == MAX_COL) begin
`ifdef CURSOR_WRAP_EN
        w_cursor_nxt = '0;
`else
        w_cursor_nxt = r_cursor;
`endif
      end else begin
        w_cursor_nxt = r_cursor + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cursor <= COL_W'(START_COL);
    else        r_cursor <= w_cursor_nxt;
  end

  // A full FIFO still takes a drop when the controller frees a slot in the same cycle.
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_pop   = w_valid && bus.cmd_ready;
  assign w_wr_en = bus.btn_drop && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr] <= r_cursor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (bus.btn_drop && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign bus.cursor_col = r_cursor;
  assign bus.cmd_valid  = w_valid;
  assign bus.cmd_col    = r_mem[r_rd_ptr];
  assign bus.fifo_count = r_count;
  assign bus.overflow   = r_overflow;
endmodule
